// File: rtl/risc_spm_pkg.sv
// Shared RISC_SPM definitions: bus widths and the RAM dump engine state encoding.
package risc_spm_pkg;

  localparam int word_size = 8;
  localparam int addr_size = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/ram_dump_unit.sv
// RAM readout engine: scans an inclusive address range after HALT and streams
// (address, word) pairs over valid/ready while accumulating a modular checksum.
//
// state | meaning
// IDLE  | bus released; waits for a legal start, pulses error on an illegal one
// FETCH | owns the RAM bus; captures mem_data/mem_addr into the output register
// SEND  | word presented; held until dout_ready, then checksum update and advance
// DONE  | one-cycle done pulse, bus released
module ram_dump_unit
  import risc_spm_pkg::*;
#(
  parameter int word_size_p = word_size,
  parameter int addr_size_p = addr_size
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halted,
  input  logic [addr_size_p-1:0] base_addr,
  input  logic [addr_size_p-1:0] last_addr,
  output logic                   mem_sel,
  output logic [addr_size_p-1:0] mem_addr,
  input  logic [word_size_p-1:0] mem_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [addr_size_p-1:0] dout_addr,
  output logic [word_size_p-1:0] dout_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [word_size_p-1:0] checksum
);

  localparam logic [addr_size_p-1:0] addr_one = {{(addr_size_p-1){1'b0}}, 1'b1};

  dump_state_t state_q, state_d;

  logic [addr_size_p-1:0] mem_addr_q, mem_addr_d;
  logic [addr_size_p-1:0] last_q, last_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [addr_size_p-1:0] dout_addr_q, dout_addr_d;
  logic [word_size_p-1:0] dout_data_q, dout_data_d;
  logic [word_size_p-1:0] checksum_q, checksum_d;
  logic                   error_q, error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      last_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_addr_q  <= '0;
      dout_data_q  <= '0;
      checksum_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      last_q       <= last_d;
      dout_valid_q <= dout_valid_d;
      dout_addr_q  <= dout_addr_d;
      dout_data_q  <= dout_data_d;
      checksum_q   <= checksum_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    last_d       = last_q;
    dout_valid_d = dout_valid_q;
    dout_addr_d  = dout_addr_q;
    dout_data_d  = dout_data_q;
    checksum_d   = checksum_q;
    error_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (halted && (last_addr >= base_addr)) begin
            last_d     = last_addr;
            mem_addr_d = base_addr;
            checksum_d = '0;
            state_d    = FETCH;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      FETCH: begin
        dout_data_d  = mem_data;
        dout_addr_d  = mem_addr_q;
        dout_valid_d = 1'b1;
        state_d      = SEND;
      end

      SEND: begin
        if (dout_ready) begin
          checksum_d   = checksum_q + dout_data_q;
          dout_valid_d = 1'b0;
          // End test precedes the increment so a range ending at the top address never wraps.
          if (mem_addr_q == last_q) begin
            state_d = DONE;
          end else begin
            mem_addr_d = mem_addr_q + addr_one;
            state_d    = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_sel    = (state_q == FETCH) || (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_addr   = mem_addr_q;
  assign dout_valid = dout_valid_q;
  assign dout_addr  = dout_addr_q;
  assign dout_data  = dout_data_q;
  assign checksum   = checksum_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ram_dump_unit.sv
// Self-checking bench for ram_dump_unit: table-driven dumps against a RAM model,
// plus backpressure, ignored-start, reset-mid-dump and full-range sequences.
module tb_ram_dump_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       halted;
  logic [7:0] base_addr;
  logic [7:0] last_addr;
  logic       mem_sel;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout_addr;
  logic [7:0] dout_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_data = mem[mem_addr];

  ram_dump_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halted     (halted),
    .base_addr  (base_addr),
    .last_addr  (last_addr),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_addr  (dout_addr),
    .dout_data  (dout_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] last;
    logic       halted;
    logic       exp_err;
    int         exp_n;
    logic [7:0] exp_cks;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_sel"}, {31'd0, mem_sel}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
    check({tag, "_dout_addr"}, {24'd0, dout_addr}, 32'd0);
    check({tag, "_dout_data"}, {24'd0, dout_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
  endtask

  // Issues a start and follows the dump to completion. stall_addr/stall_len hold
  // dout_ready low on one word; poke_start fires an illegal start mid-dump.
  task automatic run_dump(input string tag, input logic [7:0] b, input logic [7:0] l,
                          input logic h, input logic exp_err, input int exp_n,
                          input logic [7:0] exp_cks, input int stall_addr,
                          input int stall_len, input logic poke_start);
    int         n;
    int         cyc;
    int         stalls;
    int         exp_a;
    logic       seen_done;
    logic       prev_stalled;
    logic [7:0] prev_a;
    logic [7:0] prev_d;
    logic [7:0] prev_cks;

    base_addr  = b;
    last_addr  = l;
    halted     = h;
    dout_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;

    if (exp_err) begin
      check({tag, "_error_pulse"}, {31'd0, error}, 32'd1);
      check({tag, "_error_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_error_cks"}, {24'd0, checksum}, {24'd0, exp_cks});
      tick();
      check({tag, "_error_clear"}, {31'd0, error}, 32'd0);
      check({tag, "_error_idle"}, {31'd0, busy}, 32'd0);
    end else begin
      check({tag, "_c1_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_c1_mem_sel"}, {31'd0, mem_sel}, 32'd1);
      check({tag, "_c1_valid"}, {31'd0, dout_valid}, 32'd0);
      check({tag, "_c1_error"}, {31'd0, error}, 32'd0);
      cyc          = 1;
      n            = 0;
      exp_a        = int'(b);
      stalls       = 0;
      seen_done    = 1'b0;
      prev_stalled = 1'b0;
      prev_a       = '0;
      prev_d       = '0;
      prev_cks     = '0;
      while (!seen_done && cyc < 600) begin
        if (prev_stalled) begin
          check({tag, "_hold_valid"}, {31'd0, dout_valid}, 32'd1);
          check({tag, "_hold_addr"}, {24'd0, dout_addr}, {24'd0, prev_a});
          check({tag, "_hold_data"}, {24'd0, dout_data}, {24'd0, prev_d});
          check({tag, "_hold_cks"}, {24'd0, checksum}, {24'd0, prev_cks});
        end
        prev_stalled = 1'b0;
        start        = 1'b0;
        if (done) begin
          seen_done = 1'b1;
          check({tag, "_done_cycle"}, cyc, 2 * exp_n + 1 + stall_len);
          check({tag, "_done_mem_sel"}, {31'd0, mem_sel}, 32'd0);
          check({tag, "_word_count"}, n, exp_n);
          check({tag, "_checksum"}, {24'd0, checksum}, {24'd0, exp_cks});
        end else if (dout_valid) begin
          if (int'(dout_addr) == stall_addr && stalls < stall_len) begin
            dout_ready   = 1'b0;
            stalls++;
            prev_stalled = 1'b1;
            prev_a       = dout_addr;
            prev_d       = dout_data;
            prev_cks     = checksum;
          end else begin
            dout_ready = 1'b1;
            check({tag, "_word_addr"}, {24'd0, dout_addr}, exp_a);
            check({tag, "_word_data"}, {24'd0, dout_data}, {24'd0, mem[exp_a[7:0]]});
            n++;
            exp_a++;
          end
        end else begin
          dout_ready = 1'b1;
        end
        if (poke_start && cyc == 3) begin
          start     = 1'b1;
          base_addr = 8'd0;
          last_addr = 8'd0;
          halted    = 1'b0;
        end
        if (!seen_done) begin
          tick();
          cyc++;
        end
      end
      if (!seen_done) check({tag, "_timeout"}, 32'd0, 32'd1);
      dout_ready = 1'b1;
      tick();
      check({tag, "_post_done"}, {31'd0, done}, 32'd0);
      check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_post_cks"}, {24'd0, checksum}, {24'd0, exp_cks});
    end
  endtask

  initial begin
    vec_t vecs [6];
    int   guard;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[128] = 8'd6;
    mem[129] = 8'd1;
    mem[130] = 8'd2;
    mem[131] = 8'd0;
    mem[139] = 8'hF0;

    rst        = 1'b1;
    start      = 1'b0;
    halted     = 1'b0;
    base_addr  = '0;
    last_addr  = '0;
    dout_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    vecs[0] = '{base: 8'd128, last: 8'd131, halted: 1'b1, exp_err: 1'b0, exp_n: 4, exp_cks: 8'd9};
    vecs[1] = '{base: 8'd128, last: 8'd131, halted: 1'b0, exp_err: 1'b1, exp_n: 0, exp_cks: 8'd9};
    vecs[2] = '{base: 8'd140, last: 8'd139, halted: 1'b1, exp_err: 1'b1, exp_n: 0, exp_cks: 8'd9};
    vecs[3] = '{base: 8'd139, last: 8'd139, halted: 1'b1, exp_err: 1'b0, exp_n: 1, exp_cks: 8'hF0};
    vecs[4] = '{base: 8'd130, last: 8'd131, halted: 1'b1, exp_err: 1'b0, exp_n: 2, exp_cks: 8'd2};
    vecs[5] = '{base: 8'd127, last: 8'd129, halted: 1'b1, exp_err: 1'b0, exp_n: 3, exp_cks: 8'd7};

    for (int v = 0; v < 6; v++) begin
      run_dump($sformatf("vec%0d", v), vecs[v].base, vecs[v].last, vecs[v].halted,
               vecs[v].exp_err, vecs[v].exp_n, vecs[v].exp_cks, -1, 0, 1'b0);
      tick();
    end

    run_dump("backpressure", 8'd128, 8'd131, 1'b1, 1'b0, 4, 8'd9, 129, 3, 1'b0);
    tick();

    run_dump("ignored_start", 8'd128, 8'd131, 1'b1, 1'b0, 4, 8'd9, -1, 0, 1'b1);
    tick();

    // Reset while word 130 is stalled in SEND, then replay from the base.
    base_addr  = 8'd128;
    last_addr  = 8'd131;
    halted     = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(dout_valid && dout_addr == 8'd130) && guard < 20) begin
      tick();
      guard++;
    end
    check("rst_mid_reached_130", {31'd0, dout_valid && dout_addr == 8'd130}, 32'd1);
    dout_ready = 1'b0;
    rst        = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst        = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("rst_mid_stays_idle", {31'd0, busy}, 32'd0);
    run_dump("replay", 8'd128, 8'd131, 1'b1, 1'b0, 4, 8'd9, -1, 0, 1'b0);
    tick();

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[255] = 8'hFF;
    run_dump("full_range", 8'd0, 8'd255, 1'b1, 1'b0, 256, 8'hFF, -1, 0, 1'b0);
    check("full_range_no_wrap", {24'd0, mem_addr}, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dump_unit.md
# ram_dump_unit

Memory readout engine for the RISC_SPM system, the read-side counterpart of program/data loading. After the processor halts, it takes over the RAM address bus and scans an inclusive address range. It streams each (address, word) pair out over a valid/ready handshake and accumulates a modulo-2^word_size checksum. It sits beside `top`'s RAM and is selected through an address-bus mux driven by `mem_sel`.

## Interface
- `word_size`, default 8: RAM word width.
- `addr_size`, default 8: RAM address width (256 words).
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a dump; sampled only in IDLE.
- `halted` in 1: processor HALT status; a dump is only legal while high.
- `base_addr` in addr_size: first address, inclusive.
- `last_addr` in addr_size: final address, inclusive.
- `mem_sel` out 1: high while the unit owns the RAM address bus.
- `mem_addr` out addr_size: RAM read address.
- `mem_data` in word_size: RAM read data, combinational from `mem_addr`.
- `dout_valid` out 1: output word valid.
- `dout_ready` in 1: consumer accepts the word.
- `dout_addr` out addr_size: address of the presented word.
- `dout_data` out word_size: presented word.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a dump.
- `error` out 1: one-cycle pulse on a rejected start.
- `checksum` out word_size: sum of accepted words mod 2^word_size; held until the next accepted start.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On `start` with `halted`=1 and `last_addr >= base_addr`: latch both addresses, set `mem_addr`=base, clear `checksum`, go to FETCH.
  - On `start` with `halted`=0 or `last_addr < base_addr`: pulse `error` for one cycle, stay in IDLE, leave `checksum` unchanged.
- FETCH: `mem_sel`=1. Register `mem_data`→`dout_data` and `mem_addr`→`dout_addr`, set `dout_valid`, go to SEND.
- SEND: hold `dout_valid`, `dout_data` and `dout_addr` stable until `dout_ready`=1. On handshake:
  - Update `checksum += dout_data` (truncated to word_size).
  - Clear `dout_valid`.
  - If current address == latched last, go to DONE. Otherwise increment `mem_addr` and go to FETCH.
- DONE: `done`=1 for one cycle, `mem_sel`=0, return to IDLE.
- `start` is ignored while `busy`. A fall of `halted` mid-dump is ignored; the dump completes.
- Address never wraps. The end test compares before incrementing, so base=0, last=255 yields exactly 256 words and the counter is never incremented past 255.
- `rst` in any state, including mid-handshake: next cycle all outputs are 0 (`mem_sel`, `mem_addr`, `dout_*`, `busy`, `done`, `error`, `checksum`) and the state is IDLE. A pending word is dropped.

## Timing
- Reset value of every output: 0.
- With `start` accepted at edge N:
  - `busy` and `mem_sel` are high from N+1.
  - First `dout_valid` is high from N+2.
- With `dout_ready` tied high, throughput is one word per 2 cycles. For n words, `done` is high in cycle 2n+1 after the start edge. `mem_sel` falls in the same cycle `done` rises.
- Backpressure adds one cycle per stalled cycle. Data must not change while `dout_valid`=1 and `dout_ready`=0.
- `error` is asserted the cycle after the rejected `start` edge.

## Structure
- Shared package `risc_spm_pkg`:
  - `word_size` / `addr_size` constants.
  - `dump_state_t` enum (IDLE, FETCH, SEND, DONE).
- Single module; the checksum accumulator and address counter are inline. No sub-module is warranted.
- The RAM address mux (processor vs. dump unit, keyed on `mem_sel`) lives in `top`, not in this block.

## Test plan
- **Data range.** Memory 128..131 = 6,1,2,0, `halted`=1, base=128, last=131, ready high → words (128,6),(129,1),(130,2),(131,0) in order. `checksum`=9, `done` in cycle 9 after start.
- **Full range.** Flushed memory with memory[255]=0xFF, base=0, last=255 → 256 transfers, last address 255 with no wrap. `checksum`=0xFF.
- **Backpressure.** `dout_ready` low for 3 cycles on word 129 → `dout_valid`/`dout_data`=1/`dout_addr`=129 held stable. Checksum updates only on handshake; final value still 9.
- **Rejected starts.**
  - `start` with `halted`=0 → `error` pulse, `busy` stays 0.
  - base=140, last=139 → `error` pulse.
  - Single word base=last=139 (0xF0) → one transfer, `checksum`=0xF0.
- **Reset mid-dump.** Assert `rst` during SEND of word 130 → all outputs 0 next cycle. A fresh start then replays from the base address correctly.
- **Ignored start.** `start` pulsed while `busy` → no effect on the sequence or the checksum.
